// File: rtl/qupls_alu_sched_pkg.sv
// qupls_alu_sched_pkg
//   Shared types for the Qupls ALU lane issue scheduler: operation class,
//   result exception code and scheduler state encodings.
//   Other issue logic may import this package to decode req_kind or res_exc.
package qupls_alu_sched_pkg;

  // Operation class carried on req_kind. The reserved code issues as single-cycle.
  typedef enum logic [1:0] {
    ALK_SINGLE = 2'd0,
    ALK_MUL    = 2'd1,
    ALK_DIV    = 2'd2,
    ALK_RSVD   = 2'd3
  } alu_kind_t;

  // Exception code returned with a result.
  typedef enum logic [1:0] {
    ASX_NONE    = 2'd0,
    ASX_DBZ     = 2'd1,
    ASX_DIV_TMO = 2'd2
  } alu_sched_exc_t;

  // Scheduler state encodings.
  localparam logic [1:0] AS_IDLE = 2'd0;
  localparam logic [1:0] AS_MUL  = 2'd1;
  localparam logic [1:0] AS_DIV  = 2'd2;
  localparam logic [1:0] AS_HOLD = 2'd3;

  // True for classes that occupy the lane for more than one cycle.
  function automatic logic kind_is_multi(input alu_kind_t k);
    return (k == ALK_MUL) || (k == ALK_DIV);
  endfunction

endpackage

// File: rtl/qupls_rr_arb.sv
// qupls_rr_arb
//   Rotating-priority one-hot arbiter. The search starts at i_ptr and wraps
//   modulo N; the first active request wins. Purely combinational; the caller
//   owns the pointer register and decides when to advance it.
// Ports:
//   i_req  N-bit request vector
//   i_ptr  index of the highest-priority requester this cycle (must be < N)
//   o_gnt  one-hot grant (zero when no request)
//   o_idx  index of the winner (zero when no request)
//   o_any  at least one request present
module qupls_rr_arb #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // One extra bit so ptr+offset cannot overflow before the wrap.
  logic [W:0] w_k;

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_k   = '0;
    // Scan from the farthest offset down so the nearest hit is written last.
    for (int i = N - 1; i >= 0; i--) begin
      w_k = {1'b0, i_ptr} + (W+1)'(i);
      if (w_k >= (W+1)'(N)) begin
        w_k = w_k - (W+1)'(N);
      end
      if (i_req[w_k[W-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_k[W-1:0];
      end
    end
    o_gnt = o_any ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/qupls_alu_sched.sv
// qupls_alu_sched
//   Issue scheduler for one Qupls ALU lane. Picks one of NREQ reservation
//   station requesters with rotating priority, strobes the ALU load for
//   multiply/divide, times the multi-cycle ops and returns a tagged result
//   to writeback with back-pressure.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_req            per-requester issue request (level)
//   i_req_kind       2 bits per requester, alu_kind_t
//   i_req_tag        TAGW bits per requester, destination tag
//   o_gnt, o_alu_sel one-hot grant and its index (combinational)
//   o_alu_ld         ALU load strobe on a multiply/divide grant (combinational)
//   i_div_done       divider finished; i_div_dbz valid with it
//   i_wb_rdy         writeback accepts the result this cycle
//   i_flush          abort in-flight op, drop any pending result
//   o_res_valid, o_res_tag, o_res_exc   registered result to writeback
//   o_busy           lane occupied by a multi-cycle op or a stalled result
//
// state   | meaning
// IDLE    | may issue; single-cycle results also live here while held
// MUL     | multiply in flight, counting down the fixed latency
// DIV     | divide in flight, waiting for div_done or timeout
// HOLD    | multi-cycle result presented, waiting for wb_rdy
module qupls_alu_sched
  import qupls_alu_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TAGW    = 6,
  parameter int MUL_LAT = 4,
  parameter int DIV_MAX = 140
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           i_req,
  input  logic [2*NREQ-1:0]         i_req_kind,
  input  logic [TAGW*NREQ-1:0]      i_req_tag,
  output logic [NREQ-1:0]           o_gnt,
  output logic [$clog2(NREQ)-1:0]   o_alu_sel,
  output logic                      o_alu_ld,
  input  logic                      i_div_done,
  input  logic                      i_div_dbz,
  input  logic                      i_wb_rdy,
  input  logic                      i_flush,
  output logic                      o_res_valid,
  output logic [TAGW-1:0]           o_res_tag,
  output logic [1:0]                o_res_exc,
  output logic                      o_busy
);

  localparam int SELW    = $clog2(NREQ);
  localparam int CNT_MAX = (DIV_MAX > MUL_LAT) ? DIV_MAX : MUL_LAT;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  logic [1:0]           r_state;
  logic [SELW-1:0]      r_ptr;
  logic [CNTW-1:0]      r_cnt;
  logic [TAGW-1:0]      r_op_tag;
  logic                 r_res_valid;
  logic [TAGW-1:0]      r_res_tag;
  alu_sched_exc_t       r_res_exc;

  logic [1:0]           w_kind_a [NREQ];
  logic [TAGW-1:0]      w_tag_a  [NREQ];
  logic [NREQ-1:0]      w_arb_gnt;
  logic [SELW-1:0]      w_idx;
  logic                 w_any;
  logic                 w_elig;
  logic                 w_issue;
  alu_kind_t            w_kind;
  logic [TAGW-1:0]      w_tag;
  logic [SELW-1:0]      w_ptr_nxt;
  logic                 w_multi;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_kind_a[g] = i_req_kind[2*g +: 2];
    assign w_tag_a[g]  = i_req_tag[TAGW*g +: TAGW];
  end

  qupls_rr_arb #(
    .N (NREQ),
    .W (SELW)
  ) u_arb (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Issue only from IDLE, and only if any presented result leaves this cycle.
  assign w_elig    = (r_state == AS_IDLE) && (!r_res_valid || i_wb_rdy) && !i_flush && !rst;
  assign w_issue   = w_elig && w_any;
  assign w_kind    = alu_kind_t'(w_kind_a[w_idx]);
  assign w_tag     = w_tag_a[w_idx];
  assign w_multi   = kind_is_multi(w_kind);
  assign w_ptr_nxt = (w_idx == SELW'(NREQ - 1)) ? '0 : w_idx + SELW'(1);

  assign o_gnt     = w_issue ? w_arb_gnt : '0;
  assign o_alu_sel = w_issue ? w_idx : '0;
  assign o_alu_ld  = w_issue && w_multi;

  assign o_res_valid = r_res_valid;
  assign o_res_tag   = r_res_tag;
  assign o_res_exc   = r_res_exc;
  // The stall term follows wb_rdy directly so upstream sees the stall in the
  // same cycle writeback refuses the result.
  assign o_busy      = (r_state != AS_IDLE) || (r_res_valid && !i_wb_rdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= AS_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_op_tag    <= '0;
      r_res_valid <= 1'b0;
      r_res_tag   <= '0;
      r_res_exc   <= ASX_NONE;
    end else if (i_flush) begin
      // Pointer is deliberately kept so fairness survives a flush.
      r_state     <= AS_IDLE;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_exc   <= ASX_NONE;
    end else begin
      case (r_state)
        AS_IDLE: begin
          if (w_issue) begin
            r_ptr <= w_ptr_nxt;
            case (w_kind)
              ALK_MUL: begin
                r_op_tag    <= w_tag;
                r_cnt       <= CNTW'(MUL_LAT - 1);
                r_res_valid <= 1'b0;
                r_state     <= AS_MUL;
              end
              ALK_DIV: begin
                r_op_tag    <= w_tag;
                r_cnt       <= CNTW'(DIV_MAX);
                r_res_valid <= 1'b0;
                r_state     <= AS_DIV;
              end
              default: begin
                r_res_valid <= 1'b1;
                r_res_tag   <= w_tag;
                r_res_exc   <= ASX_NONE;
              end
            endcase
          end else if (i_wb_rdy) begin
            r_res_valid <= 1'b0;
          end
        end

        AS_MUL: begin
          r_cnt <= r_cnt - CNTW'(1);
          // Finishing on the step into zero lands res_valid at alu_ld + MUL_LAT.
          if (r_cnt <= CNTW'(1)) begin
            r_cnt       <= '0;
            r_res_valid <= 1'b1;
            r_res_tag   <= r_op_tag;
            r_res_exc   <= ASX_NONE;
            r_state     <= i_wb_rdy ? AS_IDLE : AS_HOLD;
          end
        end

        AS_DIV: begin
          r_cnt <= r_cnt - CNTW'(1);
          if (i_div_done) begin
            r_cnt       <= '0;
            r_res_valid <= 1'b1;
            r_res_tag   <= r_op_tag;
            r_res_exc   <= i_div_dbz ? ASX_DBZ : ASX_NONE;
            r_state     <= i_wb_rdy ? AS_IDLE : AS_HOLD;
          end else if (r_cnt <= CNTW'(1)) begin
            r_cnt       <= '0;
            r_res_valid <= 1'b1;
            r_res_tag   <= r_op_tag;
            r_res_exc   <= ASX_DIV_TMO;
            r_state     <= i_wb_rdy ? AS_IDLE : AS_HOLD;
          end
        end

        AS_HOLD: begin
          if (i_wb_rdy) begin
            r_res_valid <= 1'b0;
            r_state     <= AS_IDLE;
          end
        end

        default: r_state <= AS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qupls_alu_sched.sv
module tb_qupls_alu_sched;

  localparam int NREQ    = 4;
  localparam int TAGW    = 6;
  localparam int MUL_LAT = 4;
  localparam int DIV_MAX = 140;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    req_kind;
  logic [TAGW*NREQ-1:0] req_tag;
  logic [NREQ-1:0]      gnt;
  logic [1:0]           alu_sel;
  logic                 alu_ld;
  logic                 div_done;
  logic                 div_dbz;
  logic                 wb_rdy;
  logic                 flush;
  logic                 res_valid;
  logic [TAGW-1:0]      res_tag;
  logic [1:0]           res_exc;
  logic                 busy;

  int n_vec  = 0;
  int n_miss = 0;
  logic [5:0] exp_tag [4];

  qupls_alu_sched #(
    .NREQ    (NREQ),
    .TAGW    (TAGW),
    .MUL_LAT (MUL_LAT),
    .DIV_MAX (DIV_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (req),
    .i_req_kind  (req_kind),
    .i_req_tag   (req_tag),
    .o_gnt       (gnt),
    .o_alu_sel   (alu_sel),
    .o_alu_ld    (alu_ld),
    .i_div_done  (div_done),
    .i_div_dbz   (div_dbz),
    .i_wb_rdy    (wb_rdy),
    .i_flush     (flush),
    .o_res_valid (res_valid),
    .o_res_tag   (res_tag),
    .o_res_exc   (res_exc),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  initial begin
    exp_tag[0] = 6'h10;
    exp_tag[1] = 6'h11;
    exp_tag[2] = 6'h15;
    exp_tag[3] = 6'h13;
    rst      = 1'b1;
    req      = 4'b1111;
    req_kind = '0;
    req_tag  = {6'h13, 6'h15, 6'h11, 6'h10};
    div_done = 1'b0;
    div_dbz  = 1'b0;
    wb_rdy   = 1'b1;
    flush    = 1'b0;
    tick();
    tick();

    // reset state, requests present but reset held
    check("rst gnt", gnt, 0);
    check("rst alu_sel", alu_sel, 0);
    check("rst alu_ld", alu_ld, 0);
    check("rst res_valid", res_valid, 0);
    check("rst res_tag", res_tag, 0);
    check("rst res_exc", res_exc, 0);
    check("rst busy", busy, 0);
    rst = 1'b0;

    // round robin over singles; requester 3 uses reserved kind 3
    req_kind = 8'hC0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr gnt", gnt, 32'(1) << (i % 4));
      check("rr alu_sel", alu_sel, i % 4);
      check("rr alu_ld", alu_ld, 0);
      tick();
      check("rr res_valid", res_valid, 1);
      check("rr res_tag", res_tag, exp_tag[i % 4]);
    end
    req = '0;
    req_kind = '0;
    tick();
    check("rr drain", res_valid, 0);

    // multiply from requester 2 (ptr now 1, so only req[2] requests at issue)
    req_kind = 8'h10;
    req = 4'b0100;
    #1;
    check("mul gnt", gnt, 4'b0100);
    check("mul alu_ld", alu_ld, 1);
    check("mul alu_sel", alu_sel, 2);
    tick();
    req_kind = '0;
    req = 4'b1011;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check("mul blocked gnt", gnt, 0);
      check("mul busy", busy, 1);
      check("mul res_valid early", res_valid, 0);
      tick();
    end
    check("mul res_valid", res_valid, 1);
    check("mul res_tag", res_tag, 6'h15);
    check("mul res_exc", res_exc, 0);
    check("mul next gnt", gnt, 4'b1000);
    check("mul busy after", busy, 0);
    tick();
    req = '0;
    check("mul follow tag", res_tag, 6'h13);
    check("mul follow valid", res_valid, 1);
    tick();
    check("mul drain", res_valid, 0);

    // divide with divide-by-zero reported at N+20
    req_kind = 8'h02;
    req = 4'b0001;
    #1;
    check("div gnt", gnt, 4'b0001);
    check("div alu_ld", alu_ld, 1);
    tick();
    req = '0;
    req_kind = '0;
    repeat (19) tick();
    div_done = 1'b1;
    div_dbz  = 1'b1;
    #1;
    check("div pending valid", res_valid, 0);
    check("div busy", busy, 1);
    tick();
    div_done = 1'b0;
    div_dbz  = 1'b0;
    check("div res_valid", res_valid, 1);
    check("div res_exc dbz", res_exc, 1);
    check("div res_tag", res_tag, 6'h10);
    tick();
    check("div drain", res_valid, 0);

    // divide timeout from requester 1
    req_kind = 8'h08;
    req = 4'b0010;
    #1;
    check("tmo gnt", gnt, 4'b0010);
    check("tmo alu_ld", alu_ld, 1);
    tick();
    req = '0;
    req_kind = '0;
    repeat (139) tick();
    check("tmo early valid", res_valid, 0);
    check("tmo busy", busy, 1);
    tick();
    check("tmo res_valid", res_valid, 1);
    check("tmo res_exc", res_exc, 2);
    check("tmo res_tag", res_tag, 6'h11);
    tick();
    check("tmo drain", res_valid, 0);

    // back-pressure on a single-cycle result
    req = 4'b0100;
    #1;
    check("bp gnt", gnt, 4'b0100);
    tick();
    req = 4'b1111;
    wb_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp gnt held", gnt, 0);
      check("bp busy", busy, 1);
      check("bp res_valid", res_valid, 1);
      check("bp res_tag", res_tag, 6'h15);
      tick();
    end
    wb_rdy = 1'b1;
    #1;
    check("bp release gnt", gnt, 4'b1000);
    check("bp release busy", busy, 0);
    tick();
    req = '0;
    check("bp next tag", res_tag, 6'h13);
    check("bp next valid", res_valid, 1);
    tick();
    check("bp drain", res_valid, 0);

    // flush during divide, coincident with div_done
    req_kind = 8'h02;
    req = 4'b0001;
    #1;
    check("fl gnt", gnt, 4'b0001);
    check("fl alu_ld", alu_ld, 1);
    tick();
    req = '0;
    req_kind = '0;
    tick();
    tick();
    req = 4'b1111;
    div_done = 1'b1;
    div_dbz  = 1'b1;
    flush    = 1'b1;
    #1;
    check("fl gnt in div", gnt, 0);
    tick();
    div_done = 1'b0;
    div_dbz  = 1'b0;
    #1;
    check("fl res_valid", res_valid, 0);
    check("fl busy idle", busy, 0);
    check("fl gnt in idle", gnt, 0);
    tick();
    flush = 1'b0;
    #1;
    check("fl res_valid after", res_valid, 0);
    check("fl ptr kept gnt", gnt, 4'b0010);
    tick();
    req = '0;
    check("fl next tag", res_tag, 6'h11);
    check("fl next valid", res_valid, 1);
    tick();

    // reset in the middle of a multiply
    req_kind = 8'h10;
    req = 4'b0100;
    #1;
    check("mr gnt", gnt, 4'b0100);
    check("mr alu_ld", alu_ld, 1);
    tick();
    req = '0;
    req_kind = '0;
    tick();
    rst = 1'b1;
    req = 4'b1111;
    tick();
    check("mr gnt", gnt, 0);
    check("mr alu_sel", alu_sel, 0);
    check("mr alu_ld", alu_ld, 0);
    check("mr res_valid", res_valid, 0);
    check("mr res_tag", res_tag, 0);
    check("mr res_exc", res_exc, 0);
    check("mr busy", busy, 0);
    rst = 1'b0;
    #1;
    check("mr first gnt", gnt, 4'b0001);
    tick();
    req = '0;
    check("mr first tag", res_tag, 6'h10);
    check("mr first valid", res_valid, 1);
    tick();
    check("mr drain", res_valid, 0);
    check("mr idle busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
